se_sram_srw_access_ctrl: RTL and testbench

//  Request-side front end for the se_sram_srw_* single-port SRAM wrappers.
//  - Converts a valid/ready request stream (read/write) into SRAM select/read_not_write/write_enable strobes.
//  - Absorbs the SRAM's one-cycle read latency into a 2-entry response buffer with valid/ready backpressure.
//  - Sits between a bus/master interface and one SRAM instance.

---
 rtl/se_sram_srw_access_ctrl_pkg.sv | 24 ++
 rtl/se_sram_srw_access_ctrl_if.sv | 36 +++
 rtl/se_sram_srw_access_ctrl_chk.sv | 22 ++
 rtl/se_sram_srw_access_ctrl_resp_fifo.sv | 64 ++++++
 rtl/se_sram_srw_access_ctrl.sv | 161 ++++++++++++++++
 tb/tb_se_sram_srw_access_ctrl.sv | 246 ++++++++++++++++++++++++
 6 files changed

// File: rtl/se_sram_srw_access_ctrl_pkg.sv
// Shared types and constants for the se_sram_srw access controller.
//   acc_state_e  : controller mode (CLEAR sweep after reset, or RUN)
//   RESP_DEPTH   : read-response buffer depth
//   CREDIT_WIDTH : width of the buffer count and read-credit values
//   calc_credit  : free response slots left after the buffered and in-flight reads
package se_sram_acc_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } acc_state_e;

  localparam int RESP_DEPTH   = 2;
  localparam int CREDIT_WIDTH = $clog2(RESP_DEPTH + 1);

  // An in-flight read already owns a buffer slot; a pop in the same cycle does not free one.
  function automatic logic [CREDIT_WIDTH-1:0] calc_credit(
    input logic [CREDIT_WIDTH-1:0] count,
    input logic                    inflight
  );
    return CREDIT_WIDTH'(RESP_DEPTH) - count - {{(CREDIT_WIDTH-1){1'b0}}, inflight};
  endfunction

endpackage

// File: rtl/se_sram_srw_access_ctrl_if.sv
// Request/response handshake bundle between a bus master and the SRAM access controller.
//   req_valid/req_ready    : request handshake
//   req_write              : 1 = write, 0 = read
//   req_address            : request address
//   req_write_data         : write data
//   req_write_enable       : write lane enables
//   resp_valid/resp_ready  : read-response handshake
//   resp_data              : read data, in request order
// Modports: master (request issuer / response consumer), slave (the controller).
interface se_sram_srw_access_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int WE_WIDTH   = 1
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_write_data;
  logic [WE_WIDTH-1:0]   req_write_enable;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;

  modport master (
    output req_valid, req_write, req_address, req_write_data, req_write_enable, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_address, req_write_data, req_write_enable, resp_ready,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/se_sram_srw_access_ctrl_chk.sv
// Checker for the read-response FIFO: flags a push while the FIFO is already full.
//   clk, rst : clock and synchronous active-high reset
//   push     : FIFO push strobe
//   count    : current FIFO occupancy
module se_sram_acc_resp_fifo_chk
  import se_sram_acc_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  input logic                    push,
  input logic [CREDIT_WIDTH-1:0] count
);

  // Overflow check, sampled on each rising edge outside reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count == CREDIT_WIDTH'(RESP_DEPTH))))
        else $error("resp fifo push while full");
    end
  end

endmodule

// File: rtl/se_sram_srw_access_ctrl_resp_fifo.sv
// Two-entry in-order FIFO holding SRAM read data until the consumer takes it.
//   clk, rst  : clock and synchronous active-high reset
//   push      : store push_data (caller guarantees space)
//   push_data : data to store
//   pop       : drop the head entry (caller guarantees count != 0)
//   count     : occupancy 0..RESP_DEPTH
//   head      : oldest entry
module se_sram_acc_resp_fifo
  import se_sram_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [CREDIT_WIDTH-1:0] count,
  output logic [DATA_WIDTH-1:0]   head
);

  localparam logic [CREDIT_WIDTH-1:0] COUNT_ONE = {{(CREDIT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0]   mem_r [RESP_DEPTH];
  logic                    wr_ptr_r;
  logic                    rd_ptr_r;
  logic [CREDIT_WIDTH-1:0] count_r;

  // Storage, pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RESP_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  se_sram_acc_resp_fifo_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .count (count_r)
  );

endmodule

// File: rtl/se_sram_srw_access_ctrl.sv
// Request-side front end for a se_sram_srw_* single-port SRAM.
// Turns valid/ready read/write requests into SRAM strobes and buffers read data
// (one-cycle SRAM latency) in a 2-entry FIFO with valid/ready backpressure.
//   sram_clock, sram_reset : clock, synchronous active-high reset
//   sram_clock__enable     : clock enable, low freezes all state and idles the outputs
//   bus (slave modport)    : req_* request channel and resp_* response channel
//   sram_select .. sram_write_enable : strobes to the SRAM
//   sram_data_out          : SRAM read data, valid one enabled cycle after a read select
// Optional feature: define SRAM_ACC_CLEAR_EN to zero the whole SRAM after reset
// (CLEAR sweep, requests held off) before entering RUN.
module se_sram_srw_access_ctrl
  import se_sram_acc_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int WE_WIDTH   = 1
) (
  input  logic                  sram_clock,
  input  logic                  sram_reset,
  input  logic                  sram_clock__enable,
  se_sram_srw_access_ctrl_if.slave bus,
  output logic                  sram_select,
  output logic                  sram_read_not_write,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [DATA_WIDTH-1:0] sram_write_data,
  output logic [WE_WIDTH-1:0]   sram_write_enable,
  input  logic [DATA_WIDTH-1:0] sram_data_out
);

  logic                    active;
  logic                    in_run;
  logic                    sweeping;
  logic [ADDR_WIDTH-1:0]   sweep_addr;
  logic                    inflight_r;
  logic [CREDIT_WIDTH-1:0] count;
  logic [CREDIT_WIDTH-1:0] credit;
  logic [DATA_WIDTH-1:0]   head;
  logic                    ready_s;
  logic                    accept_s;
  logic                    read_accept_s;
  logic                    push_s;
  logic                    pop_s;

  // Outputs stay idle while reset is asserted, not just after the first reset edge.
  assign active = sram_clock__enable & ~sram_reset;

`ifdef SRAM_ACC_CLEAR_EN
  acc_state_e            state_r;
  logic [ADDR_WIDTH-1:0] sweep_addr_r;

  // Mode FSM: sweep every address once after reset, then serve requests.
  always_ff @(posedge sram_clock) begin
    if (sram_reset) begin
      state_r      <= CLEAR;
      sweep_addr_r <= '0;
    end else if (sram_clock__enable) begin
      case (state_r)
        CLEAR: begin
          if (sweep_addr_r == {ADDR_WIDTH{1'b1}}) begin
            state_r <= RUN;
          end else begin
            state_r <= CLEAR;
          end
          sweep_addr_r <= sweep_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
        RUN: begin
          state_r      <= RUN;
          sweep_addr_r <= sweep_addr_r;
        end
        default: begin
          state_r      <= CLEAR;
          sweep_addr_r <= '0;
        end
      endcase
    end else begin
      state_r      <= state_r;
      sweep_addr_r <= sweep_addr_r;
    end
  end

  assign in_run     = (state_r == RUN);
  assign sweeping   = ~in_run;
  assign sweep_addr = sweep_addr_r;
`else
  assign in_run     = 1'b1;
  assign sweeping   = 1'b0;
  assign sweep_addr = '0;
`endif

  assign credit = calc_credit(count, inflight_r);

  // Request acceptance: writes need no buffer slot, reads need a free credit.
  always_comb begin
    ready_s = 1'b0;
    if (active && in_run) begin
      if (bus.req_write) begin
        ready_s = 1'b1;
      end else begin
        ready_s = (credit != '0);
      end
    end else begin
      ready_s = 1'b0;
    end
  end

  assign bus.req_ready = ready_s;
  assign accept_s      = bus.req_valid & ready_s;
  assign read_accept_s = accept_s & ~bus.req_write;

  // SRAM strobe drive: sweep write, accepted request, or idle zeros.
  always_comb begin
    sram_select         = 1'b0;
    sram_read_not_write = 1'b0;
    sram_address        = '0;
    sram_write_data     = '0;
    sram_write_enable   = '0;
    if (active && sweeping) begin
      sram_select       = 1'b1;
      sram_address      = sweep_addr;
      sram_write_enable = '1;
    end else if (accept_s) begin
      sram_select         = 1'b1;
      sram_read_not_write = ~bus.req_write;
      sram_address        = bus.req_address;
      sram_write_data     = bus.req_write_data;
      sram_write_enable   = bus.req_write ? bus.req_write_enable : '0;
    end else begin
      sram_select = 1'b0;
    end
  end

  // In-flight flag: set by a read accept, held across disabled cycles so the
  // capture lands on the next enabled edge while the SRAM holds data_out.
  always_ff @(posedge sram_clock) begin
    if (sram_reset) begin
      inflight_r <= 1'b0;
    end else if (sram_clock__enable) begin
      inflight_r <= read_accept_s;
    end else begin
      inflight_r <= inflight_r;
    end
  end

  assign push_s         = sram_clock__enable & inflight_r;
  assign bus.resp_valid = (count != '0) & sram_clock__enable;
  assign pop_s          = bus.resp_valid & bus.resp_ready;
  assign bus.resp_data  = head;

  se_sram_acc_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_resp_fifo (
    .clk       (sram_clock),
    .rst       (sram_reset),
    .push      (push_s),
    .push_data (sram_data_out),
    .pop       (pop_s),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_se_sram_srw_access_ctrl.sv
// Directed bench for se_sram_srw_access_ctrl (ADDR_WIDTH=4, DATA_WIDTH=16, WE_WIDTH=2)
// with a behavioural single-port SRAM holding 16'h1000+addr after initialisation.
module tb_se_sram_srw_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mem_init;
  logic        sel;
  logic        rnw;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  we;
  logic [15:0] dout;
  logic [15:0] mem [16];

  int total = 0;
  int bad   = 0;
  logic cleared = 1'b0;

  always #5 clk = ~clk;

  se_sram_srw_access_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .WE_WIDTH(2)) bus ();

  se_sram_srw_access_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .WE_WIDTH(2)) u_dut (
    .sram_clock          (clk),
    .sram_reset          (rst),
    .sram_clock__enable  (en),
    .bus                 (bus),
    .sram_select         (sel),
    .sram_read_not_write (rnw),
    .sram_address        (addr),
    .sram_write_data     (wdata),
    .sram_write_enable   (we),
    .sram_data_out       (dout)
  );

  // Behavioural SRAM: gated by the same enable, byte lanes, read data held until next read.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h1000 + 16'(i);
      dout <= 16'h0000;
    end else if (en && sel) begin
      if (rnw) begin
        dout <= mem[addr];
      end else begin
        if (we[0]) mem[addr][7:0]  <= wdata[7:0];
        if (we[1]) mem[addr][15:8] <= wdata[15:8];
      end
    end
  end

  function automatic logic [15:0] ival(input int i);
    if (cleared) return 16'h0000;
    return 16'h1000 + 16'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic w, input logic [3:0] a,
                         input logic [15:0] d, input logic [1:0] lanes);
    bus.req_valid        = v;
    bus.req_write        = w;
    bus.req_address      = a;
    bus.req_write_data   = d;
    bus.req_write_enable = lanes;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] lanes);
    set_req(1'b1, 1'b1, a, d, lanes);
    #1 chk("wr_ready", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(1'b0, 1'b0, 4'h0, 16'h0000, 2'b00);
  endtask

  // Read with 2-cycle latency checks; lane enables driven high to show they are masked.
  task automatic do_read(input string tag, input logic [3:0] a, input logic [15:0] exp);
    set_req(1'b1, 1'b0, a, 16'hFFFF, 2'b11);
    #1;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'h1);
    chk({tag, "_rnw"}, 32'(rnw), 32'h1);
    chk({tag, "_we"}, 32'(we), 32'h0);
    tick();
    set_req(1'b0, 1'b0, 4'h0, 16'h0000, 2'b00);
    #1 chk({tag, "_early"}, 32'(bus.resp_valid), 32'h0);
    tick();
    chk({tag, "_valid"}, 32'(bus.resp_valid), 32'h1);
    chk({tag, "_data"}, 32'(bus.resp_data), 32'(exp));
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [15:0] exp_arr [4];
    int          n;
    int          acc_cnt;
    logic        took;

    rst = 1'b1; en = 1'b1; mem_init = 1'b1; bus.resp_ready = 1'b0;
    set_req(1'b1, 1'b0, 4'h0, 16'h0000, 2'b00);
    repeat (3) tick();
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rvalid", 32'(bus.resp_valid), 32'h0);
    chk("rst_select", 32'(sel), 32'h0);
    rst = 1'b0; mem_init = 1'b0;
    set_req(1'b0, 1'b0, 4'h0, 16'h0000, 2'b00);

`ifdef SRAM_ACC_CLEAR_EN
    set_req(1'b1, 1'b0, 4'h0, 16'h0000, 2'b00);
    repeat (7) tick();
    chk("clr_addr7", 32'(addr), 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("clr_ready", 32'(bus.req_ready), 32'h0);
      chk("clr_addr", 32'(addr), 32'(i));
      chk("clr_we", 32'(we), 32'h3);
      tick();
    end
    chk("clr_run_ready", 32'(bus.req_ready), 32'h1);
    set_req(1'b0, 1'b0, 4'h0, 16'h0000, 2'b00);
    cleared = 1'b1;
    do_read("clr_rd", 4'hA, 16'h0000);
`else
    #1 chk("rel_ready", 32'(bus.req_ready), 32'h1);
`endif

    // Write then read back the same address.
    set_req(1'b1, 1'b1, 4'h3, 16'hBEEF, 2'b11);
    #1;
    chk("wr_select", 32'(sel), 32'h1);
    chk("wr_rnw", 32'(rnw), 32'h0);
    chk("wr_we", 32'(we), 32'h3);
    chk("wr_addr", 32'(addr), 32'h3);
    tick();
    do_read("rd_beef", 4'h3, 16'hBEEF);

    // Low-lane-only write.
    do_write(4'h3, 16'h1234, 2'b01);
    do_read("rd_lane", 4'h3, 16'hBE34);

    // Backpressure: only two reads fit, writes still go through.
    exp_arr[0] = ival(0); exp_arr[1] = ival(1); exp_arr[2] = ival(2); exp_arr[3] = 16'hBE34;
    set_req(1'b1, 1'b0, 4'h0, 16'h0000, 2'b00);
    #1 chk("bp_rdy0", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(1'b1, 1'b0, 4'h1, 16'h0000, 2'b00);
    chk("bp_rdy1", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(1'b1, 1'b0, 4'h2, 16'h0000, 2'b00);
    chk("bp_rdy2a", 32'(bus.req_ready), 32'h0);
    tick();
    chk("bp_rdy2b", 32'(bus.req_ready), 32'h0);
    chk("bp_full_valid", 32'(bus.resp_valid), 32'h1);
    set_req(1'b1, 1'b1, 4'h5, 16'h5555, 2'b11);
    #1 chk("bp_wr_ready", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(1'b1, 1'b0, 4'h2, 16'h0000, 2'b00);
    bus.resp_ready = 1'b1;
    #1 chk("bp_nobypass", 32'(bus.req_ready), 32'h0);
    n = 0; acc_cnt = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      #1;
      if (bus.resp_valid) begin
        chk("bp_data", 32'(bus.resp_data), 32'(exp_arr[n]));
        n++;
      end
      took = bus.req_valid & bus.req_ready;
      tick();
      if (took) begin
        acc_cnt++;
        if (acc_cnt == 1) set_req(1'b1, 1'b0, 4'h3, 16'h0000, 2'b00);
        else set_req(1'b0, 1'b0, 4'h0, 16'h0000, 2'b00);
      end
    end
    bus.resp_ready = 1'b0;
    chk("bp_resp_count", 32'(n), 32'h4);
    chk("bp_acc_count", 32'(acc_cnt), 32'h2);
    #1 chk("bp_drained", 32'(bus.resp_valid), 32'h0);

    // Enable dropped the cycle after a read accept.
    set_req(1'b1, 1'b0, 4'h5, 16'h0000, 2'b00);
    #1 chk("en_rd_ready", 32'(bus.req_ready), 32'h1);
    tick();
    en = 1'b0;
    set_req(1'b1, 1'b1, 4'h6, 16'hDEAD, 2'b11);
    repeat (3) begin
      #1;
      chk("dis_ready", 32'(bus.req_ready), 32'h0);
      chk("dis_select", 32'(sel), 32'h0);
      chk("dis_rvalid", 32'(bus.resp_valid), 32'h0);
      tick();
    end
    en = 1'b1;
    set_req(1'b0, 1'b0, 4'h0, 16'h0000, 2'b00);
    #1 chk("reen_early", 32'(bus.resp_valid), 32'h0);
    tick();
    chk("reen_valid", 32'(bus.resp_valid), 32'h1);
    chk("reen_data", 32'(bus.resp_data), 32'h5555);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    do_read("rd_nowrite", 4'h6, ival(6));

    // Reset with one response buffered and one read in flight.
    set_req(1'b1, 1'b0, 4'h1, 16'h0000, 2'b00);
    tick();
    set_req(1'b1, 1'b0, 4'h2, 16'h0000, 2'b00);
    tick();
    set_req(1'b0, 1'b0, 4'h0, 16'h0000, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    #1 chk("rstmid_rvalid0", 32'(bus.resp_valid), 32'h0);
    tick();
    chk("rstmid_rvalid1", 32'(bus.resp_valid), 32'h0);
    tick();
    chk("rstmid_rvalid2", 32'(bus.resp_valid), 32'h0);
    bus.resp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
